// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, ALU op encodings and the wb/m/ex control bundle layout.
package mips_pkg;

   localparam int REG_AW = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 4;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;
   localparam int M_BRANCH    = 2;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;
   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

   typedef struct packed {
      logic [WB_W-1:0] wb;
      logic [M_W-1:0]  m;
      logic [EX_W-1:0] ex;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.wb[WB_REGWRITE] = 1'b1;
            c.ex[EX_REGDST]   = 1'b1;
            c.ex[EX_ALUOP_LO +: 2] = ALUOP_FUNCT;
         end
         OP_LW: begin
            c.wb[WB_REGWRITE] = 1'b1;
            c.wb[WB_MEMTOREG] = 1'b1;
            c.m[M_MEMREAD]    = 1'b1;
            c.ex[EX_ALUSRC]   = 1'b1;
            c.ex[EX_ALUOP_LO +: 2] = ALUOP_ADD;
         end
         OP_SW: begin
            c.m[M_MEMWRITE]   = 1'b1;
            c.ex[EX_ALUSRC]   = 1'b1;
            c.ex[EX_ALUOP_LO +: 2] = ALUOP_ADD;
         end
         OP_BEQ: begin
            c.m[M_BRANCH]     = 1'b1;
            c.ex[EX_ALUOP_LO +: 2] = ALUOP_SUB;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// Writeback port from the WB stage into decode; WB drives (master), id_stage consumes (slave).
interface id_stage_if #(parameter int XLEN = 32);
   logic            wb_regwrite;
   logic [4:0]      wb_wreg;
   logic [XLEN-1:0] wb_wdata;

   modport master (output wb_regwrite, output wb_wreg, output wb_wdata);
   modport slave  (input  wb_regwrite, input  wb_wreg, input  wb_wdata);
endinterface

// File: rtl/id_stage_reg_file.sv
// 2R1W register file, r0 hardwired to zero. ID_WB_BYPASS_EN makes same-cycle writes visible to reads.
module reg_file
   import mips_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ra1_i,
   input  logic [REG_AW-1:0] ra2_i,
   output logic [XLEN-1:0]   rd1_o,
   output logic [XLEN-1:0]   rd2_o,
   input  logic              we_i,
   input  logic [REG_AW-1:0] wa_i,
   input  logic [XLEN-1:0]   wd_i
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en;

   assign wr_en = we_i && (wa_i != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[wa_i] <= wd_i;
      end
   end

`ifdef ID_WB_BYPASS_EN
   assign rd1_o = (ra1_i == '0) ? '0 : (wr_en && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
   assign rd2_o = (ra2_i == '0) ? '0 : (wr_en && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];
`else
   assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
   assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
`endif

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: register file, control decode, sign extend, load-use hazard and the ID/EX latch.
// Optional write-through bypass in the register file under ID_WB_BYPASS_EN.
module id_stage
   import mips_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   id_npc,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [15:0]       id_instr,
   input  logic [4:0]        instr_2016,
   input  logic [4:0]        instr_1511,
   input  logic              flush,
   id_stage_if.slave         wb,
   output logic              stall,
   output logic [WB_W-1:0]   ex_wb,
   output logic [M_W-1:0]    ex_m,
   output logic [EX_W-1:0]   ex_ex,
   output logic [XLEN-1:0]   ex_npc,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [4:0]        ex_instr_2016,
   output logic [4:0]        ex_instr_1511
);

   logic [XLEN-1:0] rd1, rd2, imm_sx;
   logic            hazard;
   ctrl_t           ctrl_dec, ctrl_d, ctrl_q;

   logic [XLEN-1:0] npc_q, rd1_q, rd2_q, imm_q;
   logic [4:0]      i2016_q, i1511_q;

   reg_file #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
      .clk   (clk),
      .reset (reset),
      .ra1_i (rs),
      .ra2_i (rt),
      .rd1_o (rd1),
      .rd2_o (rd2),
      .we_i  (wb.wb_regwrite),
      .wa_i  (wb.wb_wreg),
      .wd_i  (wb.wb_wdata)
   );

   assign imm_sx   = {{(XLEN-16){id_instr[15]}}, id_instr};
   assign ctrl_dec = decode_ctrl(opcode);

   // Load in EX whose destination is a source here: insert one bubble.
   assign hazard = ctrl_q.m[M_MEMREAD] && (i2016_q != '0) &&
                   ((i2016_q == rs) || (i2016_q == rt));
   assign stall  = hazard && !flush;
   assign ctrl_d = (hazard || flush) ? '0 : ctrl_dec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q  <= '0;
         npc_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         i2016_q <= '0;
         i1511_q <= '0;
      end else begin
         ctrl_q  <= ctrl_d;
         npc_q   <= id_npc;
         rd1_q   <= rd1;
         rd2_q   <= rd2;
         imm_q   <= imm_sx;
         i2016_q <= instr_2016;
         i1511_q <= instr_1511;
      end
   end

   assign ex_wb         = ctrl_q.wb;
   assign ex_m          = ctrl_q.m;
   assign ex_ex         = ctrl_q.ex;
   assign ex_npc        = npc_q;
   assign ex_rd1        = rd1_q;
   assign ex_rd2        = rd2_q;
   assign ex_imm        = imm_q;
   assign ex_instr_2016 = i2016_q;
   assign ex_instr_1511 = i1511_q;

endmodule
